// File: rtl/clock_pkg.sv
// clock_pkg
// Shared time-of-day definitions for the RTC blocks.
//   - field widths and the largest legal value of each time field
//   - time_t: packed {hour, min, sec} layout, 24 bits, binary
//   - time_valid(): range check applied to every externally loaded time
//   - time_inc(): one-second advance with minute/hour carry and midnight wrap
package clock_pkg;

    localparam int HOUR_W = 8;
    localparam int MIN_W  = 8;
    localparam int SEC_W  = 8;
    localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 8'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 8'd59;
    localparam logic [SEC_W-1:0]  MAX_SEC  = 8'd59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } time_t;

    function automatic logic time_valid(input time_t t);
        return (t.hour <= MAX_HOUR) && (t.min <= MAX_MIN) && (t.sec <= MAX_SEC);
    endfunction

    function automatic time_t time_inc(input time_t t);
        time_t r;
        r = t;
        if (t.sec == MAX_SEC) begin
            r.sec = '0;
            if (t.min == MAX_MIN) begin
                r.min = '0;
                if (t.hour == MAX_HOUR) begin
                    r.hour = '0;
                end else begin
                    r.hour = t.hour + 1'b1;
                end
            end else begin
                r.min = t.min + 1'b1;
            end
        end else begin
            r.sec = t.sec + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Prescaler that turns the system clock into a periodic enable strobe.
// No clock is derived; tick is a single-cycle qualifier in the clk domain.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset, counter returns to 0
//   en    in  1 = count, 0 = counter frozen
//   clr   in  synchronous clear to 0, wins over counting
//   tick  out high in the cycle the counter wraps (CLK_HZ/TICK_HZ-1 -> 0)
// CLK_HZ/TICK_HZ must be an integer of at least 2.
module tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = en && (cnt_q == LAST);
    assign tick = wrap;

    // Next count: a clear restarts a full period even if this cycle would wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register; reset discards any partially elapsed period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper
// Real-time clock holding hour/min/sec in binary, 24-hour form, with one alarm.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   run          1 = advance on prescaler ticks, 0 = hold time and freeze prescaler
//   set_valid    strobe loading set_time (range checked)
//   set_time     {hour, min, sec}
//   alarm_wr     strobe loading alarm_time (range checked)
//   alarm_time   {hour, min, sec}
//   alarm_en     enables alarm_hit
//   mode12       selects 12-hour presentation on disp_hour
//   time_out     current time, 24-hour form
//   disp_hour    hour for display (24-hour, or 12/1..11 when mode12=1)
//   pm           hour >= 12, independent of mode12
//   sec_pulse    one-cycle pulse when time advances on a tick
//   alarm_hit    one-cycle pulse when time becomes equal to the alarm
//   set_err      one-cycle pulse when a set or alarm load is out of range
module rtc_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              set_valid,
    input  logic [TIME_W-1:0] set_time,
    input  logic              alarm_wr,
    input  logic [TIME_W-1:0] alarm_time,
    input  logic              alarm_en,
    input  logic              mode12,
    output logic [TIME_W-1:0] time_out,
    output logic [HOUR_W-1:0] disp_hour,
    output logic              pm,
    output logic              sec_pulse,
    output logic              alarm_hit,
    output logic              set_err
);

    localparam logic [HOUR_W-1:0] NOON = 8'd12;

    time_t time_q, time_d;
    time_t alarm_q, alarm_d;
    logic  sec_pulse_q, sec_pulse_d;
    logic  alarm_hit_q, alarm_hit_d;
    logic  set_err_q, set_err_d;

    logic  tick;
    logic  set_ok;
    logic  set_bad;
    logic  alarm_ok;
    logic  alarm_bad;

    assign set_ok    = set_valid && time_valid(time_t'(set_time));
    assign set_bad   = set_valid && !time_valid(time_t'(set_time));
    assign alarm_ok  = alarm_wr && time_valid(time_t'(alarm_time));
    assign alarm_bad = alarm_wr && !time_valid(time_t'(alarm_time));

    // An accepted set restarts the prescaler so the new second lasts a full period.
    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clr   (set_ok),
        .tick  (tick)
    );

    // Next-state for time, alarm and the strobes. A set in the same cycle as a
    // tick swallows the tick. The alarm fires only on a transition into
    // equality, so re-loading the alarm time while already matching is silent.
    always_comb begin
        time_d      = time_q;
        alarm_d     = alarm_q;
        sec_pulse_d = 1'b0;
        alarm_hit_d = 1'b0;
        set_err_d   = set_bad || alarm_bad;

        if (set_ok) begin
            time_d = time_t'(set_time);
        end else if (tick) begin
            time_d      = time_inc(time_q);
            sec_pulse_d = 1'b1;
        end

        if (alarm_ok) begin
            alarm_d = time_t'(alarm_time);
        end

        alarm_hit_d = alarm_en && (set_ok || tick) &&
                      (time_d == alarm_q) && (time_q != alarm_q);
    end

    // State and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q      <= '0;
            alarm_q     <= '0;
            sec_pulse_q <= 1'b0;
            alarm_hit_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            time_q      <= time_d;
            alarm_q     <= alarm_d;
            sec_pulse_q <= sec_pulse_d;
            alarm_hit_q <= alarm_hit_d;
            set_err_q   <= set_err_d;
        end
    end

    // Display hour: midnight and noon both show as 12 in 12-hour mode.
    always_comb begin
        pm        = (time_q.hour >= NOON);
        disp_hour = time_q.hour;
        if (mode12) begin
            if (time_q.hour == '0) begin
                disp_hour = NOON;
            end else if (time_q.hour > NOON) begin
                disp_hour = time_q.hour - NOON;
            end
        end
    end

    assign time_out  = time_q;
    assign sec_pulse = sec_pulse_q;
    assign alarm_hit = alarm_hit_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper
// Directed bench for rtc_timekeeper with CLK_HZ=10, TICK_HZ=1 (a tick every
// 10 clk). Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, away from the active edge.
module tb_rtc_timekeeper;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        set_valid;
    logic [23:0] set_time;
    logic        alarm_wr;
    logic [23:0] alarm_time;
    logic        alarm_en;
    logic        mode12;
    logic [23:0] time_out;
    logic [7:0]  disp_hour;
    logic        pm;
    logic        sec_pulse;
    logic        alarm_hit;
    logic        set_err;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] m12Hour [6] = '{8'd0, 8'd1, 8'd11, 8'd12, 8'd13, 8'd23};
    logic [7:0] m12Disp [6] = '{8'd12, 8'd1, 8'd11, 8'd12, 8'd1, 8'd11};
    logic       m12Pm   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rtc_timekeeper #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .set_valid  (set_valid),
        .set_time   (set_time),
        .alarm_wr   (alarm_wr),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .mode12     (mode12),
        .time_out   (time_out),
        .disp_hour  (disp_hour),
        .pm         (pm),
        .sec_pulse  (sec_pulse),
        .alarm_hit  (alarm_hit),
        .set_err    (set_err)
    );

    // 10 time-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applySet(input logic [23:0] v);
        set_valid = 1'b1;
        set_time  = v;
        stepClk();
        set_valid = 1'b0;
    endtask

    task automatic applyAlarm(input logic [23:0] v);
        alarm_wr   = 1'b1;
        alarm_time = v;
        stepClk();
        alarm_wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checkCount++;
        if (time_out !== 24'h000000) $display("[TB] FAIL reset_time: got %h expected %h", time_out, 24'h000000);
        else passCount++;
        checkCount++;
        if (sec_pulse !== 1'b0) $display("[TB] FAIL reset_sec_pulse: got %b expected 0", sec_pulse);
        else passCount++;
        checkCount++;
        if (alarm_hit !== 1'b0) $display("[TB] FAIL reset_alarm_hit: got %b expected 0", alarm_hit);
        else passCount++;
        checkCount++;
        if (set_err !== 1'b0) $display("[TB] FAIL reset_set_err: got %b expected 0", set_err);
        else passCount++;
        checkCount++;
        if (disp_hour !== 8'd0 || pm !== 1'b0) $display("[TB] FAIL reset_disp: got %0d/%b expected 0/0", disp_hour, pm);
        else passCount++;
        stepClk();
        rst_n = 1'b1;
        stepClk();
    endtask

    task automatic test_rollover();
        int pulses;
        pulses = 0;
        run = 1'b0;
        applySet(24'h173B3A);
        checkCount++;
        if (time_out !== 24'h173B3A) $display("[TB] FAIL rollover_set: got %h expected %h", time_out, 24'h173B3A);
        else passCount++;
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            stepClk();
            if (sec_pulse === 1'b1) pulses++;
            if (i == 10) begin
                checkCount++;
                if (time_out !== 24'h173B3B) $display("[TB] FAIL rollover_235959: got %h expected %h", time_out, 24'h173B3B);
                else passCount++;
            end
            if (i == 20) begin
                checkCount++;
                if (time_out !== 24'h000000) $display("[TB] FAIL rollover_midnight: got %h expected %h", time_out, 24'h000000);
                else passCount++;
            end
        end
        run = 1'b0;
        checkCount++;
        if (pulses !== 2) $display("[TB] FAIL rollover_pulses: got %0d expected 2", pulses);
        else passCount++;
    endtask

    task automatic test_carry();
        run = 1'b0;
        applySet(24'h0A3B3B);
        run = 1'b1;
        repeat (10) stepClk();
        run = 1'b0;
        checkCount++;
        if (time_out !== 24'h0B0000) $display("[TB] FAIL carry_time: got %h expected %h", time_out, 24'h0B0000);
        else passCount++;
        checkCount++;
        if (sec_pulse !== 1'b1) $display("[TB] FAIL carry_sec_pulse: got %b expected 1", sec_pulse);
        else passCount++;
        checkCount++;
        if (disp_hour !== 8'd11 || pm !== 1'b0) $display("[TB] FAIL carry_disp: got %0d/%b expected 11/0", disp_hour, pm);
        else passCount++;
    endtask

    task automatic test_reject();
        run = 1'b0;
        applySet(24'h183000);
        checkCount++;
        if (set_err !== 1'b1) $display("[TB] FAIL reject_hour_err: got %b expected 1", set_err);
        else passCount++;
        checkCount++;
        if (time_out !== 24'h0B0000) $display("[TB] FAIL reject_hour_time: got %h expected %h", time_out, 24'h0B0000);
        else passCount++;
        stepClk();
        checkCount++;
        if (set_err !== 1'b0) $display("[TB] FAIL reject_err_width: got %b expected 0", set_err);
        else passCount++;
        applySet(24'h013C00);
        checkCount++;
        if (set_err !== 1'b1 || time_out !== 24'h0B0000) $display("[TB] FAIL reject_min: got err=%b time=%h expected err=1 time=%h", set_err, time_out, 24'h0B0000);
        else passCount++;
        applySet(24'h173B3B);
        checkCount++;
        if (set_err !== 1'b0 || time_out !== 24'h173B3B) $display("[TB] FAIL accept_max: got err=%b time=%h expected err=0 time=%h", set_err, time_out, 24'h173B3B);
        else passCount++;
        applyAlarm(24'h00003C);
        checkCount++;
        if (set_err !== 1'b1 || time_out !== 24'h173B3B) $display("[TB] FAIL reject_alarm: got err=%b time=%h expected err=1 time=%h", set_err, time_out, 24'h173B3B);
        else passCount++;
    endtask

    task automatic test_alarm();
        int hits;
        int hitIdx;
        logic [23:0] hitTime;
        hits = 0;
        hitIdx = 0;
        hitTime = '0;
        run = 1'b0;
        alarm_en = 1'b1;
        applyAlarm(24'h000005);
        applySet(24'h000000);
        run = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            stepClk();
            if (alarm_hit === 1'b1) begin
                hits++;
                hitIdx = i;
                hitTime = time_out;
            end
        end
        run = 1'b0;
        checkCount++;
        if (hits !== 1) $display("[TB] FAIL alarm_count_en: got %0d expected 1", hits);
        else passCount++;
        checkCount++;
        if (hitTime !== 24'h000005 || hitIdx !== 50) $display("[TB] FAIL alarm_when: got time=%h clk=%0d expected time=%h clk=50", hitTime, hitIdx, 24'h000005);
        else passCount++;

        hits = 0;
        alarm_en = 1'b0;
        applySet(24'h000000);
        run = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            stepClk();
            if (alarm_hit === 1'b1) hits++;
        end
        run = 1'b0;
        checkCount++;
        if (hits !== 0) $display("[TB] FAIL alarm_count_dis: got %0d expected 0", hits);
        else passCount++;
        checkCount++;
        if (time_out !== 24'h000007) $display("[TB] FAIL alarm_dis_time: got %h expected %h", time_out, 24'h000007);
        else passCount++;

        alarm_en = 1'b1;
        applySet(24'h000005);
        checkCount++;
        if (alarm_hit !== 1'b1) $display("[TB] FAIL alarm_by_set: got %b expected 1", alarm_hit);
        else passCount++;
        applySet(24'h000005);
        checkCount++;
        if (alarm_hit !== 1'b0) $display("[TB] FAIL alarm_no_repeat: got %b expected 0", alarm_hit);
        else passCount++;
        alarm_en = 1'b0;
    endtask

    task automatic test_set_vs_tick();
        int early;
        early = 0;
        run = 1'b1;
        applySet(24'h000000);
        repeat (9) stepClk();
        applySet(24'h0C0000);
        checkCount++;
        if (time_out !== 24'h0C0000) $display("[TB] FAIL collide_time: got %h expected %h", time_out, 24'h0C0000);
        else passCount++;
        checkCount++;
        if (sec_pulse !== 1'b0) $display("[TB] FAIL collide_sec_pulse: got %b expected 0", sec_pulse);
        else passCount++;
        for (int i = 1; i <= 10; i++) begin
            stepClk();
            if (i < 10 && sec_pulse === 1'b1) early++;
            if (i == 10) begin
                checkCount++;
                if (sec_pulse !== 1'b1 || time_out !== 24'h0C0001) $display("[TB] FAIL collide_next_tick: got pulse=%b time=%h expected pulse=1 time=%h", sec_pulse, time_out, 24'h0C0001);
                else passCount++;
            end
        end
        checkCount++;
        if (early !== 0) $display("[TB] FAIL collide_early: got %0d early pulses expected 0", early);
        else passCount++;

        early = 0;
        repeat (4) stepClk();
        applySet(24'h010000);
        for (int i = 1; i <= 10; i++) begin
            stepClk();
            if (i < 10 && sec_pulse === 1'b1) early++;
            if (i == 10) begin
                checkCount++;
                if (sec_pulse !== 1'b1 || time_out !== 24'h010001) $display("[TB] FAIL midset_tick: got pulse=%b time=%h expected pulse=1 time=%h", sec_pulse, time_out, 24'h010001);
                else passCount++;
            end
        end
        run = 1'b0;
        checkCount++;
        if (early !== 0) $display("[TB] FAIL midset_early: got %0d early pulses expected 0", early);
        else passCount++;
    endtask

    task automatic test_mode12();
        run = 1'b0;
        mode12 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applySet({m12Hour[i], 16'h0000});
            checkCount++;
            if (disp_hour !== m12Disp[i] || pm !== m12Pm[i])
                $display("[TB] FAIL mode12_h%0d: got %0d/%b expected %0d/%b", m12Hour[i], disp_hour, pm, m12Disp[i], m12Pm[i]);
            else passCount++;
        end
        mode12 = 1'b0;
        #1;
        checkCount++;
        if (disp_hour !== 8'd23 || pm !== 1'b1) $display("[TB] FAIL mode24_h23: got %0d/%b expected 23/1", disp_hour, pm);
        else passCount++;
    endtask

    task automatic test_reset_midcount();
        int early;
        early = 0;
        run = 1'b1;
        applySet(24'h000003);
        repeat (5) stepClk();
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (time_out !== 24'h000000) $display("[TB] FAIL midreset_time: got %h expected %h", time_out, 24'h000000);
        else passCount++;
        stepClk();
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            stepClk();
            if (i < 10 && sec_pulse === 1'b1) early++;
            if (i == 10) begin
                checkCount++;
                if (sec_pulse !== 1'b1 || time_out !== 24'h000001) $display("[TB] FAIL midreset_tick: got pulse=%b time=%h expected pulse=1 time=%h", sec_pulse, time_out, 24'h000001);
                else passCount++;
            end
        end
        run = 1'b0;
        checkCount++;
        if (early !== 0) $display("[TB] FAIL midreset_early: got %0d early pulses expected 0", early);
        else passCount++;

        alarm_en = 1'b1;
        applySet(24'h000002);
        applySet(24'h000000);
        checkCount++;
        if (alarm_hit !== 1'b1) $display("[TB] FAIL alarm_reg_reset: got %b expected 1", alarm_hit);
        else passCount++;
        alarm_en = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        set_valid  = 1'b0;
        set_time   = '0;
        alarm_wr   = 1'b0;
        alarm_time = '0;
        alarm_en   = 1'b0;
        mode12     = 1'b0;

        test_reset();
        test_rollover();
        test_carry();
        test_reject();
        test_alarm();
        test_set_vs_tick();
        test_mode12();
        test_reset_midcount();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, meaning the time-advance rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic runs on this single clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  1 = time advances on each tick; 0 = time held and prescaler frozen.
REQ-006 SHALL have port set_valid  input  1  one-cycle strobe that loads set_time.
REQ-007 SHALL have port set_time  input  24  load value {hour[23:16], min[15:8], sec[7:0]}, binary.
REQ-008 SHALL have port alarm_wr  input  1  one-cycle strobe that loads alarm_time.
REQ-009 SHALL have port alarm_time  input  24  alarm value, same format as set_time.
REQ-010 SHALL have port alarm_en  input  1  enables alarm_hit.
REQ-011 SHALL have port mode12  input  1  selects the 12-hour presentation on disp_hour.
REQ-012 SHALL have port time_out  output  24  current time {hour, min, sec}, binary, 24-hour format.
REQ-013 SHALL have port disp_hour  output  8  time_out hour in 24-hour form, or 12/1..11 when mode12=1.
REQ-014 SHALL have port pm  output  1  1 when hour >= 12; valid regardless of mode12.
REQ-015 SHALL have port sec_pulse  output  1  one-cycle pulse on each time advance.
REQ-016 SHALL have port alarm_hit  output  1  one-cycle pulse on alarm match.
REQ-017 SHALL have port set_err  output  1  one-cycle pulse when a set/alarm load is rejected.

Function
REQ-018 SHALL use a prescaler counting 0..CLK_HZ/TICK_HZ-1 while run=1 and issue one tick in the cycle the counter wraps; the block SHALL derive no clock.
REQ-019 SHALL advance the time by one second on a tick: sec 59->0 with a min carry; min 59->0 with an hour carry; 23:59:59 -> 00:00:00.
REQ-020 SHALL update time_out and sec_pulse in the cycle after the tick (latency 1 clk).
REQ-021 SHALL accept set_valid only if hour<=23, min<=59 and sec<=59; an accepted set SHALL update time_out on the next clk and clear the prescaler to 0.
REQ-022 SHALL leave time_out unchanged on a rejected set or alarm load and pulse set_err for 1 clk.
REQ-023 SHALL give set_valid priority over a tick in the same cycle; that tick SHALL be discarded and sec_pulse SHALL NOT pulse.
REQ-024 SHALL apply the same range check to alarm_wr and store an accepted alarm_time in an internal register.
REQ-025 SHALL pulse alarm_hit for 1 clk when time_out becomes equal to the stored alarm through a tick or an accepted set while alarm_en=1; it SHALL NOT pulse again while the time stays equal.
REQ-026 SHALL keep run=0 from affecting set_valid or alarm_wr acceptance.
REQ-027 SHALL compute disp_hour and pm combinationally from time_out: hour 0 -> 12 with pm=0; 1..11 -> same, pm=0; 12 -> 12, pm=1; 13..23 -> hour-12, pm=1.

Reset
REQ-028 SHALL, while rst_n=0, set time_out=24'h000000, the alarm register=24'h000000, the prescaler=0, and sec_pulse, alarm_hit and set_err=0.
REQ-029 SHALL restart a full tick period after rst_n deasserts mid-count; no partial period is carried over.

Structure
REQ-030 SHALL take the field widths, MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59 and the time-range check function from the shared package clock_pkg.
REQ-031 SHALL instantiate the prescaler as sub-module tick_gen (parameters CLK_HZ, TICK_HZ; ports clk, rst_n, en, clr, tick).

Verification
REQ-032 SHALL cover, with CLK_HZ=10 and TICK_HZ=1: a set to 23:59:58 then 20 clk with run=1 -> 23:59:59, then 00:00:00, and 2 sec_pulse.
REQ-033 SHALL cover a set to 24'h0A3B3B (10:59:59) followed by 1 tick -> time_out=24'h0B0000.
REQ-034 SHALL cover set_valid with 24'h183000 (24:48:00) -> set_err pulses and time_out is unchanged.
REQ-035 SHALL cover alarm 00:00:05 with alarm_en=1 from 00:00:00 -> exactly one alarm_hit at 00:00:05, and none with alarm_en=0.
REQ-036 SHALL cover set_valid in the same cycle as a tick -> the set value is loaded, there is no sec_pulse, and the next tick occurs 10 clk later.
REQ-037 SHALL cover mode12=1 at hours 0, 12 and 23 -> disp_hour/pm of 12/0, 12/1 and 11/1.
